instr_fetch_unit: RTL and testbench
===================================

INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 16'h0000: PC value loaded on reset.
REQ-002 SHALL have parameter HLT_OPCODE, default 4'h0: opcode in bits [23:20] that marks a halt instruction.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port imem_addr, output, 16 bits: fetch address driven to instruction memory, equal to the current PC register.
REQ-006 SHALL have port imem_data, input, 24 bits: instruction word, valid combinationally in the same cycle as imem_addr.
REQ-007 SHALL have port inst_valid, output, 1 bit: a buffered instruction is presented to decode.
REQ-008 SHALL have port inst_data, output, 24 bits: presented instruction word.
REQ-009 SHALL have port inst_pc, output, 16 bits: address of the presented instruction.
REQ-010 SHALL have port inst_ready, input, 1 bit: decode accepts the instruction; a transfer occurs when inst_valid && inst_ready.
REQ-011 SHALL have port redirect_valid, input, 1 bit: single-cycle branch/jump request.
REQ-012 SHALL have port redirect_addr, input, 16 bits: new PC, sampled when redirect_valid=1.
REQ-013 SHALL have port resume, input, 1 bit: single-cycle request to leave the HALT state.
REQ-014 SHALL have port halted, output, 1 bit: state is HALT and the buffer is empty.

Function
REQ-015 SHALL implement a two-state FSM: FETCH and HALT.
REQ-016 SHALL contain a 2-entry FIFO of {pc[15:0], instr[23:0]}, with inst_valid/inst_data/inst_pc taken from its head entry.
REQ-017 In FETCH, each cycle that the FIFO has a free slot (count<2, or count==2 with a pop in the same cycle), the block SHALL push {PC, imem_data} and set PC <= PC+1.
REQ-018 PC increment SHALL wrap modulo 2^16 (16'hFFFF -> 16'h0000), with no flag or stall.
REQ-019 If the FIFO is full with no pop, the block SHALL not push and SHALL hold PC.
REQ-020 When a pushed word has [23:20]==HLT_OPCODE, the block SHALL still push that word and move FSM to HALT; PC SHALL still advance to PC+1.
REQ-021 In HALT, the block SHALL make no pushes; the FIFO SHALL continue to drain to decode normally.
REQ-022 resume=1 in HALT SHALL set FSM to FETCH; fetching SHALL restart at the held PC on the following cycle. resume SHALL be ignored in FETCH.
REQ-023 redirect_valid=1 SHALL, at that edge: flush the FIFO (count=0), set PC <= redirect_addr, and set FSM to FETCH (including from HALT); there SHALL be no push and no pop that cycle.
REQ-024 Next cycle after a redirect, inst_valid SHALL be 0; the instruction at redirect_addr SHALL be presented the cycle after that (2-cycle redirect latency).
REQ-025 Priority SHALL be rst > redirect_valid > resume > normal fetch/pop.
REQ-026 While inst_valid=1 and inst_ready=0, inst_data and inst_pc SHALL hold stable; inst_valid SHALL not drop except on redirect or rst.
REQ-027 Simultaneous push and pop SHALL keep the FIFO order and count.
REQ-028 inst_valid SHALL depend only on registered state, never combinationally on inst_ready.

Reset
REQ-029 On rst=1, the block SHALL set PC=RESET_PC, FSM=FETCH, FIFO empty, inst_valid=0, halted=0, inst_data=0 and inst_pc=0 when empty; imem_addr SHALL equal RESET_PC in the cycle after the reset edge.
REQ-030 rst asserted mid-operation SHALL discard all buffered instructions and any pending halt or redirect.
REQ-031 First inst_valid=1 SHALL occur one cycle after the first post-reset fetch cycle.

Verification
REQ-032 Program mem[0..3]=C10005,C20003,130120,000000, with inst_ready=1: the bench SHALL see inst_pc 0,1,2,3 on consecutive cycles with the matching words; after PC=3 there SHALL be no further fetch, and halted=1 one cycle after word 000000 is accepted.
REQ-033 Backpressure, inst_ready=0 for 5 cycles after reset: the bench SHALL see FIFO count 2, imem_addr held at 2, and inst_pc=0/inst_data=C10005 stable; on releasing ready, the sequence SHALL continue with no loss or duplication.
REQ-034 redirect_valid=1 with redirect_addr=16'h0001 while the FIFO holds 2 entries: next cycle inst_valid=0; following cycle inst_pc=1, inst_data=C20003.
REQ-035 In HALT with PC=4, pulse resume: the bench SHALL see imem_addr=4 the next cycle, halted=0, and the fetched word presented with inst_pc=4.
REQ-036 Redirect to 16'hFFFF: the bench SHALL see inst_pc FFFF then 0000 (wrap-around); a redirect in the same cycle as resume SHALL take the redirect target.

Source files
------------

// File: rtl/instr_fetch_unit_if.sv
// Decode-side handshake channel of the instruction fetch unit.
// The fetch unit drives the instruction; decode returns inst_ready.
interface instr_fetch_unit_if;
    logic        inst_valid;
    logic [23:0] inst_data;
    logic [15:0] inst_pc;
    logic        inst_ready;

    modport master (output inst_valid, output inst_data, output inst_pc, input inst_ready);
    modport slave  (input inst_valid, input inst_data, input inst_pc, output inst_ready);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: PC register, FETCH/HALT control and a 2-entry
// instruction buffer feeding decode, with redirect and halt/resume support.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC   = 16'h0000,
    parameter logic [3:0]  HLT_OPCODE = 4'h0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic [15:0]           imem_addr,
    input  logic [23:0]           imem_data,
    instr_fetch_unit_if.master    dec,
    input  logic                  redirect_valid,
    input  logic [15:0]           redirect_addr,
    input  logic                  resume,
    output logic                  halted
);

    localparam logic [0:0] ST_FETCH = 1'b0;
    localparam logic [0:0] ST_HALT  = 1'b1;

    logic [0:0]  state;
    logic [15:0] pc;
    logic [1:0]  count;
    logic [15:0] head_pc,    tail_pc;
    logic [23:0] head_instr, tail_instr;

    logic accept;
    logic pop_req;
    logic do_pop;
    logic do_push;

    // Reset and redirect both suppress any buffer movement in their cycle.
    assign accept  = !rst && !redirect_valid;
    assign pop_req = (count != 2'd0) && dec.inst_ready;
    assign do_pop  = accept && pop_req;
    assign do_push = accept && (state == ST_FETCH) && ((count != 2'd2) || pop_req);

    assign imem_addr      = pc;
    assign dec.inst_valid = (count != 2'd0);
    assign dec.inst_data  = dec.inst_valid ? head_instr : 24'h0;
    assign dec.inst_pc    = dec.inst_valid ? head_pc    : 16'h0;
    assign halted         = (state == ST_HALT) && (count == 2'd0);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_FETCH;
            pc    <= RESET_PC;
            count <= 2'd0;
        end else if (redirect_valid) begin
            state <= ST_FETCH;
            pc    <= redirect_addr;
            count <= 2'd0;
        end else begin
            if ((state == ST_HALT) && resume)
                state <= ST_FETCH;
            if (do_push) begin
                pc <= pc + 16'd1;
                if (imem_data[23:20] == HLT_OPCODE)
                    state <= ST_HALT;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    // NOTE: buffer slots carry no reset; they are only observed through the
    // count-qualified outputs, so stale contents are never visible.
    always_ff @(posedge clk) begin
        case ({do_push, do_pop})
            2'b10: begin
                if (count == 2'd0) begin
                    head_pc    <= pc;
                    head_instr <= imem_data;
                end else begin
                    tail_pc    <= pc;
                    tail_instr <= imem_data;
                end
            end
            2'b01: begin
                head_pc    <= tail_pc;
                head_instr <= tail_instr;
            end
            2'b11: begin
                // Pop and push together: the new word lands behind whatever remains.
                if (count == 2'd1) begin
                    head_pc    <= pc;
                    head_instr <= imem_data;
                end else begin
                    head_pc    <= tail_pc;
                    head_instr <= tail_instr;
                    tail_pc    <= pc;
                    tail_instr <= imem_data;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations plus randomized traffic compared against a queue-based model.
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam logic [3:0]  HLT      = 4'h0;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] imem_addr;
    logic [23:0] imem_data;
    logic        redirect_valid;
    logic [15:0] redirect_addr;
    logic        resume;
    logic        halted;

    always #5 clk = ~clk;

    instr_fetch_unit_if dec_if ();

    logic [23:0] mem [0:65535];
    assign imem_data = mem[imem_addr];

    instr_fetch_unit #(.RESET_PC(RESET_PC), .HLT_OPCODE(HLT)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .dec            (dec_if.master),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .resume         (resume),
        .halted         (halted)
    );

    typedef struct packed {
        logic [15:0] pc;
        logic [23:0] w;
    } entry_t;

    entry_t      q[$];
    logic [15:0] m_pc;
    bit          m_halt;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: buffer is a queue, halt is a flag, pc is plain arithmetic.
    task automatic model_advance();
        bit pop, push;
        if (rst) begin
            q.delete();
            m_pc   = RESET_PC;
            m_halt = 1'b0;
        end else if (redirect_valid) begin
            q.delete();
            m_pc   = redirect_addr;
            m_halt = 1'b0;
        end else begin
            pop  = (q.size() > 0) && dec_if.inst_ready;
            push = !m_halt && ((q.size() < 2) || pop);
            if (m_halt && resume)
                m_halt = 1'b0;
            if (pop)
                void'(q.pop_front());
            if (push) begin
                q.push_back({m_pc, mem[m_pc]});
                if (mem[m_pc][23:20] == HLT)
                    m_halt = 1'b1;
                m_pc = m_pc + 16'd1;
            end
        end
    endtask

    task automatic compare_all();
        logic        e_valid;
        logic [23:0] e_data;
        logic [15:0] e_pc;
        e_valid = (q.size() != 0);
        e_data  = e_valid ? q[0].w  : 24'h0;
        e_pc    = e_valid ? q[0].pc : 16'h0;
        check("inst_valid", 32'(dec_if.inst_valid), 32'(e_valid));
        check("inst_data",  32'(dec_if.inst_data),  32'(e_data));
        check("inst_pc",    32'(dec_if.inst_pc),    32'(e_pc));
        check("imem_addr",  32'(imem_addr),         32'(m_pc));
        check("halted",     32'(halted),            32'(m_halt && (q.size() == 0)));
    endtask

    // Drive one cycle of inputs, advance the model, then compare after the edge.
    task automatic step(input bit rdy, input bit rd, input logic [15:0] ra, input bit res, input bit r);
        rst               = r;
        dec_if.inst_ready = rdy;
        redirect_valid    = rd;
        redirect_addr     = ra;
        resume            = res;
        model_advance();
        @(negedge clk);
        compare_all();
    endtask

    logic [23:0] prog [4];

    initial begin
        rst = 1'b1; dec_if.inst_ready = 1'b0; redirect_valid = 1'b0;
        redirect_addr = 16'h0; resume = 1'b0;
        for (int i = 0; i < 65536; i++)
            mem[i] = 24'($urandom);
        prog[0] = 24'hC10005; prog[1] = 24'hC20003; prog[2] = 24'h130120; prog[3] = 24'h000000;
        for (int i = 0; i < 4; i++)
            mem[i] = prog[i];
        mem[4]        = 24'h5A0004;
        mem[16'h0010] = 24'h812345;
        mem[16'hFFFF] = 24'h7ABCDE;

        // Reset state
        step(0, 0, 16'h0, 0, 1);
        step(0, 0, 16'h0, 0, 1);
        check("rst_valid",  32'(dec_if.inst_valid), 32'h0);
        check("rst_addr",   32'(imem_addr),         32'h0000);
        check("rst_halted", 32'(halted),            32'h0);
        check("rst_data",   32'(dec_if.inst_data),  32'h0);
        check("rst_pc",     32'(dec_if.inst_pc),    32'h0);

        // Straight-line program ending in a halt word
        for (int i = 0; i < 4; i++) begin
            step(1, 0, 16'h0, 0, 0);
            check("prog_valid", 32'(dec_if.inst_valid), 32'h1);
            check("prog_pc",    32'(dec_if.inst_pc),    32'(i));
            check("prog_data",  32'(dec_if.inst_data),  32'(prog[i]));
        end
        check("prog_not_halted_yet", 32'(halted), 32'h0);
        step(1, 0, 16'h0, 0, 0);
        check("halt_halted", 32'(halted),    32'h1);
        check("halt_addr",   32'(imem_addr), 32'h0004);
        step(1, 0, 16'h0, 0, 0);
        check("halt_hold_addr", 32'(imem_addr),         32'h0004);
        check("halt_no_valid",  32'(dec_if.inst_valid), 32'h0);

        // Resume from HALT at the held PC
        step(1, 0, 16'h0, 1, 0);
        check("resume_halted", 32'(halted),    32'h0);
        check("resume_addr",   32'(imem_addr), 32'h0004);
        step(1, 0, 16'h0, 0, 0);
        check("resume_pc",   32'(dec_if.inst_pc),   32'h0004);
        check("resume_data", 32'(dec_if.inst_data), 32'h5A0004);

        // Backpressure after reset
        step(0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 16'h0, 0, 0);
            check("bp_pc",   32'(dec_if.inst_pc),   32'h0000);
            check("bp_data", 32'(dec_if.inst_data), 32'hC10005);
        end
        check("bp_addr", 32'(imem_addr), 32'h0002);
        for (int i = 1; i < 4; i++) begin
            step(1, 0, 16'h0, 0, 0);
            check("bp_release_pc", 32'(dec_if.inst_pc), 32'(i));
        end

        // Redirect with a full buffer
        step(0, 0, 16'h0, 0, 1);
        step(0, 0, 16'h0, 0, 0);
        step(0, 0, 16'h0, 0, 0);
        step(0, 1, 16'h0001, 0, 0);
        check("redir_gap_valid", 32'(dec_if.inst_valid), 32'h0);
        step(0, 0, 16'h0, 0, 0);
        check("redir_pc",   32'(dec_if.inst_pc),   32'h0001);
        check("redir_data", 32'(dec_if.inst_data), 32'hC20003);

        // Redirect to the top of the address space, PC wraps
        step(1, 1, 16'hFFFF, 0, 0);
        check("wrap_gap_valid", 32'(dec_if.inst_valid), 32'h0);
        step(1, 0, 16'h0, 0, 0);
        check("wrap_pc_ffff", 32'(dec_if.inst_pc),   32'hFFFF);
        check("wrap_data",    32'(dec_if.inst_data), 32'h7ABCDE);
        step(1, 0, 16'h0, 0, 0);
        check("wrap_pc_0000", 32'(dec_if.inst_pc), 32'h0000);

        // Redirect and resume together in HALT: redirect target wins
        step(1, 1, 16'h0003, 0, 0);
        step(1, 0, 16'h0, 0, 0);
        step(1, 0, 16'h0, 0, 0);
        check("pre_rr_halted", 32'(halted), 32'h1);
        step(1, 1, 16'h0010, 1, 0);
        check("rr_valid",  32'(dec_if.inst_valid), 32'h0);
        check("rr_halted", 32'(halted),            32'h0);
        step(1, 0, 16'h0, 0, 0);
        check("rr_pc",   32'(dec_if.inst_pc),   32'h0010);
        check("rr_data", 32'(dec_if.inst_data), 32'h812345);

        // Randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic [15:0] ra;
            ra = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 15))
                                             : 16'(16'hFFF0 + 16'($urandom_range(0, 15)));
            step($urandom_range(0, 9) < 7, $urandom_range(0, 29) == 0, ra,
                 $urandom_range(0, 9) == 0, $urandom_range(0, 299) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
